rs_cmd_arbiter: RTL and testbench
=================================

Name: rs_cmd_arbiter

Overview:
Controller that shares a bank of N clocked RS flip-flops (rs instances) between two requesters. Each requester issues set, clear, toggle or read commands on one flip-flop index. The block arbitrates round-robin and drives one-cycle-scale s/r pulses into the bank. It never presents s=r=1, then reads back q and returns a response. It sits between control logic and the rs bank, and is the only driver of the bank's s/r inputs.

Parameters:
N_FF, 8, number of rs flip-flops in the bank (1..2^IDX_W)
IDX_W, 3, width of the flip-flop index
SETTLE_CYC, 1, cycles s or r is held high per write (>=1)

Ports:
CLOCK_50  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 command valid; held until accepted
req0_idx  in  IDX_W  requester 0 flip-flop index
req0_op  in  2  requester 0 opcode: 00 read, 01 set, 10 clear, 11 toggle
req0_ready  out  1  requester 0 command accepted at this edge if valid
req1_valid, req1_idx, req1_op, req1_ready  same as requester 0, for requester 1
ff_s  out  N_FF  s inputs of the rs bank (registered)
ff_r  out  N_FF  r inputs of the rs bank (registered)
ff_q  in  N_FF  q outputs of the rs bank
rsp_valid  out  1  one-cycle response strobe, no back-pressure
rsp_id  out  1  requester that owns the response
rsp_q  out  1  flip-flop q sampled at end of command
rsp_err  out  1  out-of-range index or readback mismatch

Behaviour:
- Reset, asynchronous: FSM goes to IDLE. ff_s=0, ff_r=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0, last_served=1 so req0 wins first. Any pending command is dropped. The rs bank's own state is not touched.
- FSM states are IDLE, DRIVE, HOLD, RESP.
- IDLE: the grant is combinational. If only one requester is valid, it is granted. If both are valid, the requester that is not last_served is granted. reqN_ready = (state==IDLE) & grant_N; ready is never high for both requesters.
- Accept edge (valid & ready):
  - latch idx, op, id; set last_served=id.
  - expected = 1 for set, 0 for clear, ~ff_q[idx] for toggle, ff_q[idx] for read, all sampled at the accept edge.
  - next state: DRIVE for set/clear/toggle; HOLD for read or for an out-of-range index (idx >= N_FF).
- DRIVE: lasts SETTLE_CYC cycles.
  - ff_s = one-hot(idx) if expected==1; else ff_r = one-hot(idx).
  - A toggle therefore becomes a set or a clear.
  - All other bits stay 0.
- HOLD: one cycle with ff_s=ff_r=0. At the end of HOLD, latch rsp_q = ff_q[idx] (0 if out of range). Latch rsp_err = out_of_range | (ff_q[idx] != expected).
- RESP: rsp_valid=1 for exactly one cycle with rsp_id/rsp_q/rsp_err stable. Then return to IDLE. No acceptance occurs in RESP.
- Latency, accept edge to rsp_valid high: SETTLE_CYC+2 cycles for writes, 2 cycles for read or out-of-range. One command is in flight at a time.
- Invariants, checked every cycle:
  - (ff_s & ff_r)==0
  - popcount(ff_s|ff_r) <= 1
  - ff_s|ff_r nonzero only in DRIVE
- Valid may drop without handshake only if it was never accepted; idx/op are sampled only at accept.
- Reset during DRIVE: ff_s/ff_r fall to 0 asynchronously and no response is produced. The bank may or may not have latched the write.

Decomposition:
- Shared header/package rs_ctrl_pkg holds:
  - opcode constants OP_READ/OP_SET/OP_CLR/OP_TOG
  - FSM state encodings
  - response error bit meaning
- One sub-module, rs_rr_arb: 2-way round-robin grant logic. Inputs are valid0/valid1/last_served; output is the grant vector.
- The top also instantiates N_FF rs flip-flops only in the bench, not in this block.

Test Plan:
- Reset: rst=1 mid-cycle -> all outputs 0 immediately. After release, req0_valid=1 and req1_valid=1 -> req0_ready=1, req1_ready=0.
- req0 set idx 3, SETTLE_CYC=1, bench rs bank -> ff_s=8'h08 for 1 cycle, ff_r=0, rsp_valid 3 cycles after accept with rsp_id=0, rsp_q=1, rsp_err=0.
- Toggle idx 3 twice from req1 after the set -> ff_r=8'h08 then ff_s=8'h08; rsp_q=0 then 1, rsp_err=0.
- Both requesters continuously valid with reads of idx 0 -> accepted ids alternate 0,1,0,1. Each rsp 2 cycles after accept. ff_s=ff_r=0 throughout.
- Config N_FF=6, req0 set idx 7 -> no s/r activity, rsp_q=0, rsp_err=1. Bench forcing ff_q[2]=0 on a set of idx 2 -> rsp_err=1.
- Reset asserted during DRIVE of set idx 5 -> ff_s=0 the same cycle, no rsp_valid. After release the next request is granted normally. The invariant assertion never fires.

Source files
------------

// File: rtl/rs_ctrl_pkg.sv
// rtl/rs_ctrl_pkg.sv - opcodes, FSM encodings and response helpers for the rs bank controller
// Contents: op_t with OP_READ/OP_SET/OP_CLR/OP_TOG; ST_IDLE/ST_DRIVE/ST_HOLD/ST_RESP;
//           RSP_OK/RSP_FAULT; expected_q() which gives the q a command should leave behind.
package rs_ctrl_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_READ = 2'b00;
    localparam op_t OP_SET  = 2'b01;
    localparam op_t OP_CLR  = 2'b10;
    localparam op_t OP_TOG  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // rsp_err: FAULT means the index was out of range or q did not read back as expected
    localparam logic RSP_OK    = 1'b0;
    localparam logic RSP_FAULT = 1'b1;

    // q value the flip-flop must show after the command, given q at accept time
    function automatic logic expected_q(input op_t op, input logic q);
        case (op)
            OP_SET:  return 1'b1;
            OP_CLR:  return 1'b0;
            OP_TOG:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/rs_rr_arb.sv
// rtl/rs_rr_arb.sv - 2-way round-robin grant
// Ports: valid0/valid1 request valids, last_served id of the last accepted requester,
//        grant one-hot (or zero) grant vector, combinational.
module rs_rr_arb (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_served,
    output logic [1:0] grant
);

    // On contention the requester that was not served last wins
    assign grant[0] = valid0 & (~valid1 | last_served);
    assign grant[1] = valid1 & (~valid0 | ~last_served);

endmodule

// File: rtl/rs_cmd_arbiter.sv
// rtl/rs_cmd_arbiter.sv - two-requester command arbiter driving a bank of clocked RS flip-flops
// Ports: CLOCK_50 clock, rst async active-high reset;
//        reqN_valid/idx/op/ready command handshake for requesters 0 and 1;
//        ff_s/ff_r registered s/r pulses to the bank, ff_q bank outputs;
//        rsp_valid/rsp_id/rsp_q/rsp_err one-cycle response.
module rs_cmd_arbiter
    import rs_ctrl_pkg::*;
#(
    parameter int N_FF       = 8,
    parameter int IDX_W      = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_idx,
    input  logic [1:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_idx,
    input  logic [1:0]       req1_op,
    output logic             req1_ready,
    output logic [N_FF-1:0]  ff_s,
    output logic [N_FF-1:0]  ff_r,
    input  logic [N_FF-1:0]  ff_q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_q,
    output logic             rsp_err
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx_q;
    logic             id_q;
    logic             exp_q;
    logic             oor_q;
    logic             last_served;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       grant;
    logic             sel_id;
    logic [IDX_W-1:0] sel_idx;
    op_t              sel_op;
    logic             sel_in_range;
    logic             sel_exp;
    logic [N_FF-1:0]  sel_shift;
    logic [N_FF-1:0]  cur_shift;
    logic [N_FF-1:0]  sel_onehot;
    logic             accept;

    rs_rr_arb u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_served (last_served),
        .grant       (grant)
    );

    assign req0_ready = (state == ST_IDLE) & grant[0];
    assign req1_ready = (state == ST_IDLE) & grant[1];
    assign accept     = req0_ready | req1_ready;

    assign sel_id       = grant[1];
    assign sel_idx      = sel_id ? req1_idx : req0_idx;
    assign sel_op       = sel_id ? req1_op  : req0_op;
    assign sel_in_range = {{(32-IDX_W){1'b0}}, sel_idx} < 32'(N_FF);

    // Shifting right reads q[idx] and naturally yields 0 for an out-of-range index
    assign sel_shift  = ff_q >> sel_idx;
    assign cur_shift  = ff_q >> idx_q;
    assign sel_exp    = expected_q(sel_op, sel_shift[0]);
    assign sel_onehot = N_FF'(1) << sel_idx;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            id_q        <= 1'b0;
            exp_q       <= 1'b0;
            oor_q       <= 1'b0;
            last_served <= 1'b1;
            cnt         <= '0;
            ff_s        <= '0;
            ff_r        <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_q       <= 1'b0;
            rsp_err     <= RSP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx_q       <= sel_idx;
                        id_q        <= sel_id;
                        last_served <= sel_id;
                        exp_q       <= sel_exp;
                        oor_q       <= ~sel_in_range;
                        cnt         <= '0;
                        if (sel_op == OP_READ || !sel_in_range) begin
                            state <= ST_HOLD;
                        end else begin
                            // A toggle resolves here into a plain set or clear
                            state <= ST_DRIVE;
                            if (sel_exp) ff_s <= sel_onehot;
                            else         ff_r <= sel_onehot;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state <= ST_HOLD;
                        ff_s  <= '0;
                        ff_r  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_q     <= cur_shift[0];
                    rsp_err   <= (oor_q || (cur_shift[0] != exp_q)) ? RSP_FAULT : RSP_OK;
                    state     <= ST_RESP;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_cmd_arbiter.sv
// tb/tb_rs_cmd_arbiter.sv - directed self-checking bench for rs_cmd_arbiter with behavioural rs banks
module tb_rs_cmd_arbiter;

    localparam logic [1:0] RD = 2'b00, ST = 2'b01, CL = 2'b10, TG = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // instance a: N_FF=8, SETTLE_CYC=1
    logic a0v = 0, a1v = 0;
    logic [2:0] a0i = 0, a1i = 0;
    logic [1:0] a0o = 0, a1o = 0;
    logic a0r, a1r;
    logic [7:0] a_s, a_r, a_q;
    logic a_rv, a_rid, a_rq, a_re;
    logic [7:0] bank_a = '0;

    // instance b: N_FF=6, SETTLE_CYC=2, with a stuck-at-0 mask on its bank outputs
    logic b0v = 0, b1v = 0;
    logic [2:0] b0i = 0, b1i = 0;
    logic [1:0] b0o = 0, b1o = 0;
    logic b0r, b1r;
    logic [5:0] b_s, b_r, b_q;
    logic b_rv, b_rid, b_rq, b_re;
    logic [5:0] bank_b = '0;
    logic [5:0] stuck_b = '0;

    int total = 0;
    int bad = 0;

    rs_cmd_arbiter #(.N_FF(8), .IDX_W(3), .SETTLE_CYC(1)) dut_a (
        .CLOCK_50(clk), .rst(rst),
        .req0_valid(a0v), .req0_idx(a0i), .req0_op(a0o), .req0_ready(a0r),
        .req1_valid(a1v), .req1_idx(a1i), .req1_op(a1o), .req1_ready(a1r),
        .ff_s(a_s), .ff_r(a_r), .ff_q(a_q),
        .rsp_valid(a_rv), .rsp_id(a_rid), .rsp_q(a_rq), .rsp_err(a_re)
    );

    rs_cmd_arbiter #(.N_FF(6), .IDX_W(3), .SETTLE_CYC(2)) dut_b (
        .CLOCK_50(clk), .rst(rst),
        .req0_valid(b0v), .req0_idx(b0i), .req0_op(b0o), .req0_ready(b0r),
        .req1_valid(b1v), .req1_idx(b1i), .req1_op(b1o), .req1_ready(b1r),
        .ff_s(b_s), .ff_r(b_r), .ff_q(b_q),
        .rsp_valid(b_rv), .rsp_id(b_rid), .rsp_q(b_rq), .rsp_err(b_re)
    );

    // clocked RS banks, not affected by rst
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (a_s[i]) bank_a[i] <= 1'b1; else if (a_r[i]) bank_a[i] <= 1'b0;
        for (int j = 0; j < 6; j++)
            if (b_s[j]) bank_b[j] <= 1'b1; else if (b_r[j]) bank_b[j] <= 1'b0;
    end
    assign a_q = bank_a;
    assign b_q = bank_b & ~stuck_b;

    // s/r invariants on every cycle, plus no bank activity while a response is out
    always @(negedge clk) begin
        total++;
        if ((a_s & a_r) != 0 || $countones(a_s | a_r) > 1 || (a_rv && (a_s | a_r) != 0)
            || (b_s & b_r) != 0 || $countones(b_s | b_r) > 1 || (b_rv && (b_s | b_r) != 0)) begin
            bad++;
            $display("FAIL invariant t=%0t a_s=%h a_r=%h b_s=%h b_r=%h", $time, a_s, a_r, b_s, b_r);
        end
    end

    task automatic drive(input bit dev_b, input bit rq, input logic v, input logic [2:0] idx, input logic [1:0] op);
        if (!dev_b && !rq) begin a0v = v; a0i = idx; a0o = op; end
        if (!dev_b &&  rq) begin a1v = v; a1i = idx; a1o = op; end
        if ( dev_b && !rq) begin b0v = v; b0i = idx; b0o = op; end
        if ( dev_b &&  rq) begin b1v = v; b1i = idx; b1o = op; end
    endtask

    function automatic logic ready_of(input bit dev_b, input bit rq);
        if (dev_b) return rq ? b1r : b0r;
        return rq ? a1r : a0r;
    endfunction

    // Issues one command and collects its response; lat counts posedges from the accept edge
    // (inclusive) to the first cycle with rsp_valid high, -1 on timeout.
    task automatic send(input bit dev_b, input bit rq, input logic [2:0] idx, input logic [1:0] op,
                        output int lat, output logic rid, output logic q, output logic err,
                        output logic [7:0] s_or, output logic [7:0] r_or, output int act);
        int w;
        lat = -1; rid = 0; q = 0; err = 0; s_or = 0; r_or = 0; act = 0;
        @(negedge clk);
        drive(dev_b, rq, 1'b1, idx, op);
        #1;
        w = 0;
        while (!ready_of(dev_b, rq) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 20) begin
            drive(dev_b, rq, 1'b0, idx, op);
            return;
        end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lat++;
            if (k == 0) drive(dev_b, rq, 1'b0, idx, op);
            s_or |= dev_b ? {2'b00, b_s} : a_s;
            r_or |= dev_b ? {2'b00, b_r} : a_r;
            if ((dev_b ? {2'b00, b_s | b_r} : (a_s | a_r)) != 0) act++;
            if (dev_b ? b_rv : a_rv) begin
                rid = dev_b ? b_rid : a_rid;
                q   = dev_b ? b_rq  : a_rq;
                err = dev_b ? b_re  : a_re;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({a_s, a_r, a_rv, a_rid, a_rq, a_re} !== 20'h0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {a_s, a_r, a_rv, a_rid, a_rq, a_re});
        end
        rst = 1'b0;
        @(negedge clk);
        drive(0, 0, 1, 3'd0, RD);
        drive(0, 1, 1, 3'd0, RD);
        #1;
        total++;
        if ({a0r, a1r} !== 2'b10) begin
            bad++; $display("FAIL reset_first_grant got=%b want=10", {a0r, a1r});
        end
        drive(0, 0, 0, 3'd0, RD);
        drive(0, 1, 0, 3'd0, RD);
    endtask

    task automatic test_set();
        int lat, act; logic rid, q, err; logic [7:0] so, ro;
        send(0, 0, 3'd3, ST, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 3 || so !== 8'h08 || ro !== 8'h00 || act != 1) begin
            bad++; $display("FAIL set_drive lat=%0d s=%h r=%h act=%0d want 3/08/00/1", lat, so, ro, act);
        end
        total++;
        if ({rid, q, err} !== 3'b010) begin
            bad++; $display("FAIL set_rsp got id/q/err=%b want 010", {rid, q, err});
        end
    endtask

    task automatic test_toggle();
        int lat, act; logic rid, q, err; logic [7:0] so, ro;
        send(0, 1, 3'd3, TG, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 3 || so !== 8'h00 || ro !== 8'h08 || {rid, q, err} !== 3'b100) begin
            bad++; $display("FAIL toggle1 lat=%0d s=%h r=%h idqe=%b want 3/00/08/100", lat, so, ro, {rid, q, err});
        end
        send(0, 1, 3'd3, TG, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 3 || so !== 8'h08 || ro !== 8'h00 || {rid, q, err} !== 3'b110) begin
            bad++; $display("FAIL toggle2 lat=%0d s=%h r=%h idqe=%b want 3/08/00/110", lat, so, ro, {rid, q, err});
        end
    endtask

    task automatic test_back_to_back();
        int w, lat; logic id;
        @(negedge clk);
        drive(0, 0, 1, 3'd0, RD);
        drive(0, 1, 1, 3'd0, RD);
        for (int n = 0; n < 4; n++) begin
            #1;
            w = 0;
            while (!(a0r | a1r) && w < 20) begin @(negedge clk); #1; w++; end
            id = a1r;
            total++;
            if (w >= 20 || (a0r & a1r) || id !== n[0]) begin
                bad++; $display("FAIL alt_grant n=%0d ready=%b%b want id=%0d", n, a0r, a1r, n[0]);
            end
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!a_rv && lat < 20);
            total++;
            if (lat != 2 || a_rid !== id || a_rq !== 1'b0 || a_re !== 1'b0) begin
                bad++; $display("FAIL alt_rsp n=%0d lat=%0d id=%b q=%b err=%b want 2/%b/0/0", n, lat, a_rid, a_rq, a_re, id);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 3'd0, RD);
        drive(0, 1, 0, 3'd0, RD);
    endtask

    task automatic test_range_settle();
        int lat, act; logic rid, q, err; logic [7:0] so, ro;
        send(1, 0, 3'd7, ST, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 2 || act != 0 || {rid, q, err} !== 3'b001) begin
            bad++; $display("FAIL oor_set lat=%0d act=%0d idqe=%b want 2/0/001", lat, act, {rid, q, err});
        end
        send(1, 1, 3'd6, RD, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 2 || {rid, q, err} !== 3'b101) begin
            bad++; $display("FAIL oor_edge lat=%0d idqe=%b want 2/101", lat, {rid, q, err});
        end
        send(1, 0, 3'd5, RD, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 2 || {rid, q, err} !== 3'b000) begin
            bad++; $display("FAIL top_idx_read lat=%0d idqe=%b want 2/000", lat, {rid, q, err});
        end
        send(1, 0, 3'd1, ST, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 4 || so !== 8'h02 || act != 2 || {rid, q, err} !== 3'b010) begin
            bad++; $display("FAIL settle2 lat=%0d s=%h act=%0d idqe=%b want 4/02/2/010", lat, so, act, {rid, q, err});
        end
        stuck_b = 6'b000100;
        send(1, 1, 3'd2, ST, lat, rid, q, err, so, ro, act);
        stuck_b = '0;
        total++;
        if (lat != 4 || so !== 8'h04 || {rid, q, err} !== 3'b101) begin
            bad++; $display("FAIL stuck_mismatch lat=%0d s=%h idqe=%b want 4/04/101", lat, so, {rid, q, err});
        end
    endtask

    task automatic test_reset_in_drive();
        int w, lat, act; logic rid, q, err; logic [7:0] so, ro;
        logic seen;
        @(negedge clk);
        drive(0, 0, 1, 3'd5, ST);
        #1;
        w = 0;
        while (!a0r && w < 20) begin @(negedge clk); #1; w++; end
        @(posedge clk); #1;
        drive(0, 0, 0, 3'd5, ST);
        total++;
        if (a_s !== 8'h20 || w >= 20) begin
            bad++; $display("FAIL drive_before_rst s=%h want 20", a_s);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (a_s !== 8'h00 || a_r !== 8'h00) begin
            bad++; $display("FAIL async_rst_sr s=%h r=%h want 00/00", a_s, a_r);
        end
        seen = 0;
        repeat (2) begin @(negedge clk); seen |= a_rv; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); seen |= a_rv; end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL rsp_after_rst got=%b want 0", seen);
        end
        // bank keeps idx3=1 across controller reset
        send(0, 1, 3'd3, RD, lat, rid, q, err, so, ro, act);
        total++;
        if (lat != 2 || {rid, q, err} !== 3'b110) begin
            bad++; $display("FAIL post_rst_read lat=%0d idqe=%b want 2/110", lat, {rid, q, err});
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_back_to_back();
        test_range_settle();
        test_reset_in_drive();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
